// File: rtl/enoc_config_pkg.sv
// Shared ENoC configuration: packet layout, widths and the traffic-generator LFSR step.
// The network fabric uses packet_t unchanged, so field order and widths are fixed here.
package enoc_config_pkg;

  localparam int DATA_W  = 32;
  localparam int TS_W    = 16;
  localparam int N_NODES = 16;
  localparam int NODE_W  = $clog2(N_NODES);

  // Galois form of x^16 + x^14 + x^13 + x^11 (right-shifting)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [NODE_W-1:0] source;
    logic [NODE_W-1:0] dest;
    logic [TS_W-1:0]   timestamp;
  } packet_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/enoc_src_fifo.sv
// Generic synchronous FIFO with registered storage and extra-MSB pointers.
// Head is read straight from storage; push while full is accepted only alongside a pop.
module enoc_src_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage is reset too so the head output is deterministic after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr_reg[AW-1:0]] <= wdata;
        wr_ptr_reg              <= wr_ptr_reg + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

  assign rdata = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/enoc_packet_source.sv
// Per-node Bernoulli traffic injector: LFSR-driven generation, stamped packets,
// a small source queue and a valid/enable handshake toward the network input.
module enoc_packet_source
  import enoc_config_pkg::*;
#(
  parameter int          NODE_ID    = 0,
  parameter int          N          = N_NODES,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic [8:0]       i_rate,
  input  logic             i_en,
  output packet_t          o_data,
  output logic             o_data_val,
  output logic             o_fifo_full,
  output logic [CNT_W-1:0] o_pkt_count,
  output logic [CNT_W-1:0] o_drop_count
);

  localparam int            NW   = $clog2(N);
  localparam logic [NW-1:0] SELF = NW'(NODE_ID);

  logic [15:0]       lfsr_reg;
  logic [TS_W-1:0]   ts_reg;
  logic [DATA_W-1:0] seq_reg;
  logic [CNT_W-1:0]  pkt_count_reg;
  logic [CNT_W-1:0]  drop_count_reg;

  logic          gen;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [NW-1:0] d_raw;
  logic [NW-1:0] d_sel;
  packet_t       new_pkt;

  assign gen = i_enable && ({1'b0, lfsr_reg[7:0]} < i_rate);

  // Self-addressed draws are bumped to the next node (wraps within NW bits).
  assign d_raw = lfsr_reg[8 +: NW];
  assign d_sel = (d_raw == SELF) ? d_raw + NW'(1) : d_raw;

  always_comb begin
    new_pkt           = '0;
    new_pkt.data      = seq_reg;
    new_pkt.source    = NODE_W'(NODE_ID);
    new_pkt.dest      = NODE_W'(d_sel);
    new_pkt.timestamp = ts_reg;
  end

  assign pop  = !empty && i_en;
  assign push = gen && (!full || pop);
  assign drop = gen && full && !pop;

  enoc_src_fifo #(
    .T     (packet_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (new_pkt),
    .rdata   (o_data),
    .full    (full),
    .empty   (empty)
  );

  // Sequence advances on every generate so dropped packets leave gaps in data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg       <= SEED;
      ts_reg         <= '0;
      seq_reg        <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      lfsr_reg <= lfsr_next(lfsr_reg);
      ts_reg   <= ts_reg + TS_W'(1);
      if (gen) begin
        seq_reg <= seq_reg + DATA_W'(1);
      end
      if (pop && (pkt_count_reg != '1)) begin
        pkt_count_reg <= pkt_count_reg + CNT_W'(1);
      end
      if (drop && (drop_count_reg != '1)) begin
        drop_count_reg <= drop_count_reg + CNT_W'(1);
      end
    end
  end

  assign o_data_val   = !empty;
  assign o_fifo_full  = full;
  assign o_pkt_count  = pkt_count_reg;
  assign o_drop_count = drop_count_reg;

endmodule
